ps2_keyboard_receiver: RTL and testbench
========================================

Name: ps2_keyboard_receiver

Overview:
- Upstream stage of the keyboard-to-character path.
- Deserialises the PS/2 keyboard line, validates frames and folds the F0 (break) and E0 (extended) prefixes into flags.
- Queues decoded scancodes in a small first-word-fall-through FIFO.
- The FIFO head `scancode` drives the address input of the scancode-to-ASCII lookup ROM; display/console logic pops entries with `rd_en`.

Parameters:
- FIFO_DEPTH, 8, number of queued decoded scancodes; power of two, ≥2.
- TIMEOUT, 50000, system-clock cycles without a PS/2 falling edge mid-frame before the partial frame is discarded.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- clrn  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS/2 clock from keyboard; asynchronous.
- ps2_data  input  1  raw PS/2 data from keyboard; asynchronous.
- rd_en  input  1  pop request from consumer.
- scancode  output  8  FIFO head code byte, without prefixes.
- is_break  output  1  FIFO head was preceded by F0.
- is_ext  output  1  FIFO head was preceded by E0.
- valid  output  1  FIFO non-empty; head fields meaningful.
- key_held  output  1  a non-break code is currently held.
- parity_err  output  1  one-cycle pulse on a rejected frame.
- overflow  output  1  sticky; a decoded code was dropped because the FIFO was full.

Behaviour:

Reset (clrn low, asynchronous):
- All outputs are 0; `scancode` = 8'h00.
- FIFO is empty; pointers are 0.
- Bit counter is 0; `brk_pending` and `ext_pending` are 0; `last_make` = 8'h00.
- The synchroniser resets to all-ones, so no spurious edge is seen on release.

Input sampling:
- `ps2_clk` and `ps2_data` each pass through a 3-flop synchroniser.
- The PS/2 falling edge is detected as sync[2]=1 and sync[1]=0.
- `ps2_data` is sampled from its synchronised copy on that edge.

Frame assembly:
- Bit counter runs 0..10.
- Bit 0 = start (must be 0), bits 1-8 = data LSB first, bit 9 = odd parity, bit 10 = stop (must be 1).
- On the edge that captures bit 10, the counter returns to 0 and the frame is evaluated in the next clk cycle.

Good frame (start=0, stop=1, XOR of data and parity = 1):
- Data = F0: set `brk_pending`; nothing is pushed.
- Data = E0: set `ext_pending`; nothing is pushed.
- Otherwise: push {ext_pending, brk_pending, data} and clear both pending flags.
- Decode latency: the entry is visible at the FIFO head 2 clk cycles after the bit-10 edge if the FIFO was empty.

Bad frame:
- `parity_err` pulses high for exactly 1 cycle.
- The frame is discarded, and both pending flags are cleared.

Timeout:
- An idle counter resets on every falling edge.
- If the bit counter ≠ 0 and the idle count reaches TIMEOUT, the bit counter returns to 0 and the partial frame is silently discarded (no `parity_err`).
- Pending flags are kept across a timeout.

FIFO:
- First-word fall-through: head fields are combinational from memory at the read pointer.
- Pop occurs when `rd_en` and `valid` are both high; the next entry appears the following cycle.
- `rd_en` while empty is ignored.
- Push while full drops the entry and sets `overflow`, which stays set until reset.
- Push and pop in the same cycle while full: both occur, and `overflow` is not set.
- Push and pop in the same cycle while empty: the push occurs and the pop is ignored.
- Pointers carry an extra wrap bit; full/empty are derived from it.

key_held (tracked at push time, independent of FIFO drops):
- Non-break code pushed: `key_held` = 1 and `last_make` = that code.
- Break code whose data equals `last_make`: `key_held` = 0.
- Break code for any other key leaves `key_held` unchanged.

Reset mid-frame:
- The partial frame, FIFO contents and flags are lost.
- The first full frame after reset decodes normally.

Test Plan:
1. Send frame 0x1C ('A', parity 0, stop 1) → `valid`=1, `scancode`=8'h1C, `is_break`=0, `is_ext`=0, `key_held`=1 two cycles after the bit-10 edge.
2. Send F0 then 1C → one FIFO entry: `scancode`=8'h1C, `is_break`=1; `key_held` returns to 0; no entry is created for F0.
3. Send E0, F0, 75 → single entry {is_ext=1, is_break=1, scancode=8'h75}; both pending flags are 0 afterwards.
4. Send 0x1C with wrong parity bit → `parity_err` high for exactly 1 cycle, `valid` stays 0; a following good 0x32 decodes with `is_break`=0.
5. Push 9 codes with `rd_en`=0 (FIFO_DEPTH=8) → `overflow`=1, 8 entries pop in order, the 9th is absent. Repeat at full with push and pop in the same cycle → no `overflow`, order preserved.
6. Send 4 bits of a frame, idle TIMEOUT+10 cycles, then a full 0x29 frame → `scancode`=8'h29, no `parity_err`. Separately, assert `clrn` low mid-frame → all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_keyboard_receiver_if.sv
// Consumer-side port bundle of the PS/2 keyboard receiver: FIFO head, pop request and status flags.
// Handshake: an entry is popped on every rising clk edge where valid && rd_en; head fields hold while valid && !rd_en.
interface ps2_keyboard_receiver_if;
  logic       rd_en;
  logic [7:0] scancode;
  logic       is_break;
  logic       is_ext;
  logic       valid;
  logic       key_held;
  logic       parity_err;
  logic       overflow;

  modport master (
    input  rd_en,
    output scancode, is_break, is_ext, valid, key_held, parity_err, overflow
  );

  modport slave (
    output rd_en,
    input  scancode, is_break, is_ext, valid, key_held, parity_err, overflow
  );
endinterface

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: synchronises the line, assembles and validates 11-bit frames, folds F0/E0
// prefixes into flags and queues decoded codes in a first-word-fall-through FIFO.
module ps2_keyboard_receiver #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk,
    input  logic ps2_data,
    ps2_keyboard_receiver_if.master kbd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]    clk_sync;
    logic [2:0]    data_sync;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [10:0]   frame;
    logic          frame_done;
    logic [TW-1:0] idle_cnt;

    logic          brk_pending;
    logic          ext_pending;
    logic [7:0]    last_make;
    logic          key_held_q;
    logic          parity_err_q;
    logic          overflow_q;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [9:0]    head;

    logic [7:0]    frame_data;
    logic          frame_good;
    logic          is_f0;
    logic          is_e0;
    logic          push_req;
    logic          fifo_empty;
    logic          fifo_full;
    logic          do_push;
    logic          do_pop;

    // Reset to ones so releasing reset with the line idle high never looks like a falling edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= 3'b111;
            data_sync <= 3'b111;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    assign fall = clk_sync[2] & ~clk_sync[1];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt    <= 4'd0;
            frame      <= 11'd0;
            frame_done <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (fall) begin
                idle_cnt       <= '0;
                frame[bit_cnt] <= data_sync[2];
                if (bit_cnt == 4'd10) begin
                    bit_cnt    <= 4'd0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                if (idle_cnt != TW'(TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;
                // A stalled partial frame is dropped silently; pending prefixes survive.
                if (bit_cnt != 4'd0 && idle_cnt == TW'(TIMEOUT)) bit_cnt <= 4'd0;
            end
        end
    end

    assign frame_data = frame[8:1];
    assign frame_good = ~frame[0] & frame[10] & (^frame[9:1]);
    assign is_f0      = (frame_data == 8'hF0);
    assign is_e0      = (frame_data == 8'hE0);
    assign push_req   = frame_done & frame_good & ~is_f0 & ~is_e0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop     = kbd.rd_en & ~fifo_empty;
    assign do_push    = push_req & (~fifo_full | do_pop);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            brk_pending  <= 1'b0;
            ext_pending  <= 1'b0;
            last_make    <= 8'h00;
            key_held_q   <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            parity_err_q <= frame_done & ~frame_good;
            if (frame_done) begin
                if (!frame_good) begin
                    brk_pending <= 1'b0;
                    ext_pending <= 1'b0;
                end else if (is_f0) begin
                    brk_pending <= 1'b1;
                end else if (is_e0) begin
                    ext_pending <= 1'b1;
                end else begin
                    brk_pending <= 1'b0;
                    ext_pending <= 1'b0;
                    // Held-key tracking follows every decoded code, even one the FIFO drops.
                    if (!brk_pending) begin
                        key_held_q <= 1'b1;
                        last_make  <= frame_data;
                    end else if (frame_data == last_make) begin
                        key_held_q <= 1'b0;
                    end
                end
            end
            if (push_req && fifo_full && !do_pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= {ext_pending, brk_pending, frame_data};
    end

    assign head           = mem[rd_ptr[AW-1:0]];
    assign kbd.valid      = ~fifo_empty;
    assign kbd.scancode   = kbd.valid ? head[7:0] : 8'h00;
    assign kbd.is_break   = kbd.valid & head[8];
    assign kbd.is_ext     = kbd.valid & head[9];
    assign kbd.key_held   = key_held_q;
    assign kbd.parity_err = parity_err_q;
    assign kbd.overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed-plus-random bench for ps2_keyboard_receiver; a queue-based keyboard model predicts FIFO
// contents, prefix folding, held-key state, overflow and parity-error pulses.
module tb_ps2_keyboard_receiver;
  localparam int DEPTH = 8;
  localparam int TMO   = 1000;

  logic clk      = 1'b0;
  logic clrn     = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_keyboard_receiver_if kbd();

  ps2_keyboard_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .clrn(clrn),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .kbd(kbd)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int perr_cnt = 0;

  always @(negedge clk) if (kbd.parity_err === 1'b1) perr_cnt++;

  // Reference keyboard model: queue of {ext, brk, code}, prefix flags, held key, sticky overflow.
  logic [9:0] exp_q[$];
  logic       m_brk, m_ext, m_held, m_ov;
  logic [7:0] m_last;

  function automatic void model_reset();
    exp_q.delete();
    m_brk = 0; m_ext = 0; m_held = 0; m_ov = 0; m_last = 8'h00;
  endfunction

  function automatic void model_frame(input logic [7:0] d, input bit good);
    if (!good) begin
      m_brk = 0; m_ext = 0;
    end else if (d == 8'hF0) begin
      m_brk = 1;
    end else if (d == 8'hE0) begin
      m_ext = 1;
    end else begin
      if (!m_brk) begin
        m_held = 1; m_last = d;
      end else if (d == m_last) begin
        m_held = 0;
      end
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, d});
      else m_ov = 1;
      m_brk = 0; m_ext = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, ".valid"}, 32'(kbd.valid), 32'(0));
    end else begin
      chk({tag, ".valid"}, 32'(kbd.valid), 32'(1));
      chk({tag, ".head"}, 32'({kbd.is_ext, kbd.is_break, kbd.scancode}), 32'(exp_q[0]));
    end
    chk({tag, ".key_held"}, 32'(kbd.key_held), 32'(m_held));
    chk({tag, ".overflow"}, 32'(kbd.overflow), 32'(m_ov));
  endtask

  task automatic pop_check(input string tag);
    chk({tag, ".pop_valid"}, 32'(kbd.valid), 32'(1));
    chk({tag, ".pop_head"}, 32'({kbd.is_ext, kbd.is_break, kbd.scancode}), 32'(exp_q[0]));
    kbd.rd_en = 1'b1;
    @(negedge clk);
    kbd.rd_en = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) pop_check(tag);
    chk({tag, ".empty"}, 32'(kbd.valid), 32'(0));
  endtask

  // One PS/2 frame; bit 10 falls exactly 4 clk edges before the line returns high so the
  // decode latency and a same-cycle pop can be lined up with the push.
  task automatic send_frame(input logic [7:0] d, input bit bad, input bit check_lat,
                            input bit pop_at_push, input int gap);
    logic [10:0] bits;
    int hp;
    hp   = $urandom_range(5, 10);
    bits = {1'b1, (~^d) ^ bad, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      repeat (hp) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (3) @(negedge clk);
        if (check_lat) chk("latency.before", 32'(kbd.valid), 32'(0));
        if (pop_at_push) begin
          chk("pop_at_push.head", 32'({kbd.is_ext, kbd.is_break, kbd.scancode}), 32'(exp_q[0]));
          kbd.rd_en = 1'b1;
          void'(exp_q.pop_front());
        end
        @(negedge clk);
        kbd.rd_en = 1'b0;
        if (check_lat) chk("latency.after", 32'(kbd.valid), 32'(1));
      end else begin
        repeat (hp) @(negedge clk);
      end
      ps2_clk = 1'b1;
      if (i == 4) repeat (gap) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (hp) @(negedge clk);
    model_frame(d, !bad);
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      repeat (8) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (8) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] c;
    do c = 8'($urandom_range(0, 255)); while (c == 8'hF0 || c == 8'hE0);
    return c;
  endfunction

  task automatic send_key(input logic [7:0] c, input bit brk, input bit ext);
    if (ext) send(8'hE0);
    if (brk) send(8'hF0);
    send(c);
  endtask

  task automatic reset_dut();
    clrn      = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    kbd.rd_en = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  initial begin
    int p0;
    kbd.rd_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset.valid", 32'(kbd.valid), 32'(0));
    chk("reset.scancode", 32'(kbd.scancode), 32'(0));
    chk("reset.flags", 32'({kbd.is_break, kbd.is_ext, kbd.key_held, kbd.parity_err, kbd.overflow}), 32'(0));
    clrn = 1'b1;
    @(negedge clk);

    // Single make code with exact decode latency.
    p0 = perr_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 0);
    check_state("t1");
    chk("t1.no_perr", 32'(perr_cnt - p0), 32'(0));
    pop_check("t1");

    // Break prefix creates no entry of its own.
    send(8'hF0);
    chk("t2.f0_no_entry", 32'(kbd.valid), 32'(0));
    send(8'h1C);
    check_state("t2");
    pop_check("t2");

    // Extended break, then prefixes must be clear for the next code.
    send_key(8'h75, 1'b1, 1'b1);
    check_state("t3");
    pop_check("t3");
    send(8'h12);
    check_state("t3.after");
    pop_check("t3.after");

    // Bad parity: one-cycle pulse, no entry, pending break cleared.
    send(8'hF0);
    p0 = perr_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 0);
    chk("t4.perr_pulse", 32'(perr_cnt - p0), 32'(1));
    check_state("t4.bad");
    send(8'h32);
    check_state("t4.next");
    pop_check("t4.next");

    // Random key traffic against the model.
    for (int i = 0; i < 8; i++) begin
      send_key(rand_code(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_state("rand");
      if ($urandom_range(0, 1) == 1) pop_check("rand");
    end
    drain("rand.drain");

    // Overflow: nine pushes into an eight-deep FIFO.
    reset_dut();
    for (int i = 0; i < DEPTH + 1; i++) send_key(rand_code(), 1'($urandom_range(0, 3) == 0), 1'b0);
    check_state("t5.full");
    chk("t5.overflow", 32'(kbd.overflow), 32'(1));
    drain("t5.drain");

    // Full FIFO with a push and pop in the same cycle.
    reset_dut();
    for (int i = 0; i < DEPTH; i++) send(rand_code());
    send_frame(rand_code(), 1'b0, 1'b0, 1'b1, 0);
    check_state("t5.simul");
    chk("t5.simul_no_ov", 32'(kbd.overflow), 32'(0));
    drain("t5.simul_drain");

    // Stalled partial frame is dropped silently.
    send_partial(4);
    repeat (TMO + 10) @(negedge clk);
    p0 = perr_cnt;
    send(8'h29);
    chk("t6.no_perr", 32'(perr_cnt - p0), 32'(0));
    check_state("t6.timeout");
    pop_check("t6.timeout");

    // A slow but live frame must not be cut short.
    send_frame(8'h4D, 1'b0, 1'b0, 1'b0, TMO - 100);
    check_state("t6.slow");

    // Asynchronous reset mid-frame with a non-empty FIFO.
    send_partial(5);
    clrn = 1'b0;
    #1;
    chk("t6.rst_valid", 32'(kbd.valid), 32'(0));
    chk("t6.rst_scancode", 32'(kbd.scancode), 32'(0));
    chk("t6.rst_flags", 32'({kbd.is_break, kbd.is_ext, kbd.key_held, kbd.parity_err, kbd.overflow}), 32'(0));
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    model_reset();
    send(8'h29);
    check_state("t6.after_rst");
    pop_check("t6.after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
